trace_tx: RTL

Hardware trace transmitter for the RISCV core's debug taps. Each cycle it samples the register-writeback and data-memory tap signals, packs each event into a 43-bit record, and buffers the records in a small FIFO. It then serialises every record as a 6-byte frame on a valid/ready byte stream toward a UART or host link, so register and memory activity can be observed on FPGA where simulation printing is unavailable.

---
 rtl/trace_pkg.sv | 40 ++++
 rtl/trace_tx_if.sv | 12 +
 rtl/trace_fifo.sv | 56 +++++
 rtl/trace_tx.sv | 131 +++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared types for the trace transmitter.
//   evt_type_e  - record type code carried in byte0 of every frame
//   trace_rec_t - one captured event {etype, index, data}, 43 bits
//   tx_state_e  - serialiser states
//   frame_byte  - selects byte n (0..5) of a record's wire frame
package trace_pkg;

    typedef enum logic [1:0] {
        EVT_NONE = 2'b00,
        EVT_REG  = 2'b01,
        EVT_MEMW = 2'b10,
        EVT_MEMR = 2'b11
    } evt_type_e;

    typedef struct packed {
        evt_type_e   etype;
        logic [8:0]  index;
        logic [31:0] data;
    } trace_rec_t;

    localparam int FRAME_BYTES = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    function automatic logic [7:0] frame_byte(input trace_rec_t rec, input logic [2:0] idx);
        case (idx)
            3'd0:    return {rec.etype, 5'b0, rec.index[8]};
            3'd1:    return rec.index[7:0];
            3'd2:    return rec.data[31:24];
            3'd3:    return rec.data[23:16];
            3'd4:    return rec.data[15:8];
            3'd5:    return rec.data[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/trace_tx_if.sv
// trace_tx_if: valid/ready byte stream from the trace transmitter.
//   tx_valid - byte on tx_data is valid (source)
//   tx_ready - sink accepts the byte this cycle (sink)
//   tx_data  - frame byte (source)
interface trace_tx_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: record FIFO with up to two pushes and one pop per cycle.
//   clk, rst       - clock, async active-low reset (empties the FIFO)
//   push_cnt       - number of records written this cycle (0..2)
//   rec_a, rec_b   - first and second record; rec_a lands first
//   pop            - advance the read pointer
//   head           - record at the read pointer
//   empty, full    - occupancy flags
//   free           - free slots, from registered pointers only
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               push_cnt,
    input  trace_rec_t               rec_a,
    input  trace_rec_t               rec_b,
    input  logic                     pop,
    output trace_rec_t               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   free
);
    localparam int AW = $clog2(DEPTH);

    trace_rec_t  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] wptr_b;
    logic [AW:0] used;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign wptr_b = wptr + (AW+1)'(1);
    assign used   = wptr - rptr;
    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign free   = (AW+1)'(DEPTH) - used;
    assign head   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + (AW+1)'(push_cnt);
            if (pop) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0) mem[wptr[AW-1:0]]   <= rec_a;
        if (push_cnt == 2'd2) mem[wptr_b[AW-1:0]] <= rec_b;
    end

endmodule

// File: rtl/trace_tx.sv
// trace_tx: captures register-writeback and data-memory tap events,
// queues them as records and serialises each as a 6-byte frame.
//   clk, rst            - clock, async active-low reset
//   trace_en            - capture enable
//   RegWriteSignal, RegNum, RegData           - register writeback tap
//   WriteEnable, ReadEnable, Address, WRData, RDData - memory tap
//   tx                  - byte stream (master side)
//   overflow            - sticky, set on any dropped event
//   drop_count          - saturating dropped-event count
//
// Serialiser states:
//   state | meaning
//   IDLE  | no frame loaded, tx_valid low
//   SEND  | frame register loaded, presenting byte byte_idx
module trace_tx
    import trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trace_en,
    input  logic              RegWriteSignal,
    input  logic [4:0]        RegNum,
    input  logic [31:0]       RegData,
    input  logic              WriteEnable,
    input  logic              ReadEnable,
    input  logic [8:0]        Address,
    input  logic [31:0]       WRData,
    input  logic [31:0]       RDData,
    trace_tx_if.master        tx,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic        reg_evt, memw_evt, memr_evt, mem_evt;
    logic [1:0]  n_evt, n_push, n_drop;
    trace_rec_t  reg_rec, mem_rec, rec_a;
    trace_rec_t  head, frame;
    logic        empty, full, pop;
    logic [AW:0] free;
    tx_state_e   state;
    logic [2:0]  byte_idx;
    logic        accept, last_byte;

    assign reg_evt  = trace_en && RegWriteSignal;
    assign memw_evt = trace_en && WriteEnable && !ReadEnable;
    assign memr_evt = trace_en && ReadEnable && !WriteEnable;
    assign mem_evt  = memw_evt || memr_evt;
    assign n_evt    = {1'b0, reg_evt} + {1'b0, mem_evt};

    assign reg_rec = '{etype: EVT_REG, index: {4'b0, RegNum}, data: RegData};
    assign mem_rec = '{etype: memw_evt ? EVT_MEMW : EVT_MEMR,
                       index: Address,
                       data:  memw_evt ? WRData : RDData};
    // REG goes first when both fire, so it is the one kept when only one slot is free.
    assign rec_a = reg_evt ? reg_rec : mem_rec;

    always_comb begin
        n_push = 2'd0;
        if (free >= (AW+1)'(n_evt)) n_push = n_evt;
        else if (!full)             n_push = 2'd1;
    end
    assign n_drop = n_evt - n_push;

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_cnt (n_push),
        .rec_a    (rec_a),
        .rec_b    (mem_rec),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .full     (full),
        .free     (free)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (n_drop != 2'd0) begin
            overflow <= 1'b1;
            if (drop_count > DROP_MAX - DROP_W'(n_drop)) drop_count <= DROP_MAX;
            else                                         drop_count <= drop_count + DROP_W'(n_drop);
        end
    end

    assign accept    = tx.tx_valid && tx.tx_ready;
    assign last_byte = accept && (byte_idx == 3'(FRAME_BYTES - 1));
    // Reload straight from the head after the last byte so frames run back to back.
    assign pop       = !empty && ((state == IDLE) || last_byte);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            byte_idx <= '0;
            frame    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        frame    <= head;
                        byte_idx <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (last_byte) begin
                            byte_idx <= '0;
                            if (!empty) frame <= head;
                            else        state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx.tx_valid = (state == SEND);
    assign tx.tx_data  = frame_byte(frame, byte_idx);

endmodule
